nn_inference_sequencer: RTL and testbench

//  Host-side driver of the 4-6-6-3 Iris network; one inference at a time.

---
 rtl/nn_inference_sequencer_pkg.sv | 18 +
 rtl/nn_inference_sequencer_if.sv | 23 ++
 rtl/nn_inference_sequencer_argmax3.sv | 28 ++
 rtl/nn_inference_sequencer.sv | 151 +++++++++++++++
 tb/tb_nn_inference_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_inference_sequencer_pkg.sv
// Shared types and constants for the Iris inference sequencer.
package nn_inference_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StCapture,
    StOut
  } nn_seq_state_t;

  // Result class encoding; CLS_NONE marks an aborted inference.
  localparam logic [1:0] CLS_Y1   = 2'd0;
  localparam logic [1:0] CLS_Y2   = 2'd1;
  localparam logic [1:0] CLS_Y3   = 2'd2;
  localparam logic [1:0] CLS_NONE = 2'd3;

endpackage

// File: rtl/nn_inference_sequencer_if.sv
// Sample and result valid/ready streams between host and sequencer.
interface nn_inference_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                           s_valid;
  logic                           s_ready;
  logic [4*DATA_WIDTH-1:0]        s_data;
  logic                           r_valid;
  logic                           r_ready;
  logic [1:0]                     r_class;
  logic signed [DATA_WIDTH+5:0]   r_score;
  logic                           r_timeout;

  modport master (
    output s_valid, s_data, r_ready,
    input  s_ready, r_valid, r_class, r_score, r_timeout
  );

  modport slave (
    input  s_valid, s_data, r_ready,
    output s_ready, r_valid, r_class, r_score, r_timeout
  );
endinterface

// File: rtl/nn_inference_sequencer_argmax3.sv
// Combinational signed 3-way max; ties resolve to the lowest index.
module nn_inference_sequencer_argmax3
  import nn_inference_sequencer_pkg::*;
#(
  parameter int unsigned W = 14
) (
  input  logic signed [W-1:0] y1_i,
  input  logic signed [W-1:0] y2_i,
  input  logic signed [W-1:0] y3_i,
  output logic [1:0]          cls_o,
  output logic signed [W-1:0] max_o
);

  // Strict greater-than keeps the earlier index on ties.
  always_comb begin
    cls_o = CLS_Y1;
    max_o = y1_i;
    if (y2_i > max_o) begin
      cls_o = CLS_Y2;
      max_o = y2_i;
    end
    if (y3_i > max_o) begin
      cls_o = CLS_Y3;
      max_o = y3_i;
    end
  end

endmodule

// File: rtl/nn_inference_sequencer.sv
// Host-side sequencer for the 4-6-6-3 Iris network: one inference at a time,
// sample in, En/Run out, wait for layer-3 Ready edge, argmax result out.
module nn_inference_sequencer
  import nn_inference_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  nn_inference_sequencer_if.slave      bus,
  output logic                         nn_en_o,
  output logic                         nn_run_o,
  output logic [DATA_WIDTH-1:0]        nn_x1_o,
  output logic [DATA_WIDTH-1:0]        nn_x2_o,
  output logic [DATA_WIDTH-1:0]        nn_x3_o,
  output logic [DATA_WIDTH-1:0]        nn_x4_o,
  input  logic signed [DATA_WIDTH+5:0] nn_y1_i,
  input  logic signed [DATA_WIDTH+5:0] nn_y2_i,
  input  logic signed [DATA_WIDTH+5:0] nn_y3_i,
  input  logic [2:0]                   nn_ready_bus_i,
  output logic                         busy_o
);

  localparam int unsigned YW = DATA_WIDTH + 6;
  localparam logic [TO_W-1:0] TimerLast = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TimerMax  = TO_W'(TIMEOUT_CYCLES);

  nn_seq_state_t                     state_q;
  logic [3:0][DATA_WIDTH-1:0]        x_q;
  logic [TO_W-1:0]                   timer_q;
  logic                              l3_q;
  logic                              s_ready_q;
  logic                              nn_en_q;
  logic                              nn_run_q;
  logic                              r_valid_q;
  logic [1:0]                        r_class_q;
  logic signed [YW-1:0]              r_score_q;
  logic                              r_timeout_q;

  logic                              l3_edge;
  logic [1:0]                        max_cls;
  logic signed [YW-1:0]              max_val;
  logic                              unused_ready;

  // Only layer 3 signals completion; lower layers are not needed here.
  assign unused_ready = ^nn_ready_bus_i[1:0];
  assign l3_edge      = nn_ready_bus_i[2] & ~l3_q;

  nn_inference_sequencer_argmax3 #(
    .W (YW)
  ) u_argmax (
    .y1_i  (nn_y1_i),
    .y2_i  (nn_y2_i),
    .y3_i  (nn_y3_i),
    .cls_o (max_cls),
    .max_o (max_val)
  );

  // Previous-cycle sample of layer-3 Ready for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      l3_q <= 1'b0;
    end else begin
      l3_q <= nn_ready_bus_i[2];
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      timer_q     <= '0;
      s_ready_q   <= 1'b0;
      nn_en_q     <= 1'b0;
      nn_run_q    <= 1'b0;
      r_valid_q   <= 1'b0;
      r_class_q   <= 2'd0;
      r_score_q   <= '0;
      r_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.s_valid && s_ready_q) begin
            x_q       <= bus.s_data;
            s_ready_q <= 1'b0;
            nn_en_q   <= 1'b1;
            nn_run_q  <= 1'b1;
            state_q   <= StStart;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        StStart: begin
          nn_run_q <= 1'b0;
          timer_q  <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          if (timer_q != TimerMax) begin
            timer_q <= timer_q + 1'b1;
          end
          // An edge in the final cycle still counts as completion.
          if (l3_edge) begin
            state_q <= StCapture;
          end else if (timer_q == TimerLast) begin
            nn_en_q     <= 1'b0;
            r_valid_q   <= 1'b1;
            r_class_q   <= CLS_NONE;
            r_score_q   <= '0;
            r_timeout_q <= 1'b1;
            state_q     <= StOut;
          end
        end
        StCapture: begin
          nn_en_q     <= 1'b0;
          r_valid_q   <= 1'b1;
          r_class_q   <= max_cls;
          r_score_q   <= max_val;
          r_timeout_q <= 1'b0;
          state_q     <= StOut;
        end
        StOut: begin
          if (bus.r_ready) begin
            r_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_class   = r_class_q;
  assign bus.r_score   = r_score_q;
  assign bus.r_timeout = r_timeout_q;

  assign nn_en_o  = nn_en_q;
  assign nn_run_o = nn_run_q;
  assign nn_x1_o  = x_q[0];
  assign nn_x2_o  = x_q[1];
  assign nn_x3_o  = x_q[2];
  assign nn_x4_o  = x_q[3];
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Scoreboard bench: driver pushes expected results, monitor pops on r_valid.
module tb_nn_inference_sequencer;

  localparam int DW      = 8;
  localparam int YW      = DW + 6;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_inference_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  logic                 nn_en, nn_run, busy;
  logic [DW-1:0]        x1, x2, x3, x4;
  logic signed [YW-1:0] y1, y2, y3;
  logic                 rdy2;
  logic [2:0]           rdy;
  assign rdy = {rdy2, 2'b00};

  nn_inference_sequencer #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .nn_en_o        (nn_en),
    .nn_run_o       (nn_run),
    .nn_x1_o        (x1),
    .nn_x2_o        (x2),
    .nn_x3_o        (x3),
    .nn_x4_o        (x4),
    .nn_y1_i        (y1),
    .nn_y2_i        (y2),
    .nn_y3_i        (y3),
    .nn_ready_bus_i (rdy),
    .busy_o         (busy)
  );

  typedef struct {
    logic [1:0]           cls;
    logic signed [YW-1:0] score;
    logic                 to;
    int                   vcyc;
    int                   rcyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Network stub: Ready[2] rises stub_delay cycles after Run (0 = never);
  // stub_pre is the level before Run, held until stub_drop cycles after Run.
  int   stub_delay = 0;
  int   stub_drop  = 0;
  logic stub_pre   = 1'b0;
  int   st_t       = 0;
  logic armed      = 1'b0;
  initial rdy2 = 1'b0;

  always @(negedge clk) begin
    if (rst) armed = 1'b0;
    else if (nn_run) begin armed = 1'b1; st_t = 0; end
    else if (nn_en && armed) st_t++;
    else armed = 1'b0;
    if (!armed) rdy2 = stub_pre;
    else if (stub_delay > 0 && st_t >= stub_delay) rdy2 = 1'b1;
    else if (st_t >= stub_drop) rdy2 = 1'b0;
    else rdy2 = stub_pre;
  end

  // Result consumer: random backpressure, or forced low for rr_hold valid cycles.
  int rr_hold = 0;
  initial begin
    bus.r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.r_valid && rr_hold > 0) begin
        rr_hold--;
        bus.r_ready = 1'b0;
      end else begin
        bus.r_ready = ($urandom_range(3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each new result and checks it stays stable.
  logic                 seen = 1'b0;
  exp_t                 cur;
  logic [1:0]           h_cls;
  logic signed [YW-1:0] h_score;
  logic                 h_to;
  int                   run_cnt = 0;
  int                   run_cyc = -1;
  int                   hs_cyc  = -1;

  always @(negedge clk) begin
    if (rst) begin
      seen    = 1'b0;
      run_cnt = 0;
    end else begin
      if (nn_run) begin
        run_cnt++;
        run_cyc = cyc;
      end
      if (busy) check("s_ready_while_busy", bus.s_ready, 0);
      if (bus.r_valid) begin
        if (!seen) begin
          seen    = 1'b1;
          h_cls   = bus.r_class;
          h_score = bus.r_score;
          h_to    = bus.r_timeout;
          if (sb.size() == 0) begin
            check("unexpected_result", sb.size(), 1);
          end else begin
            cur = sb.pop_front();
            check("r_class", bus.r_class, cur.cls);
            check("r_score", bus.r_score, cur.score);
            check("r_timeout", bus.r_timeout, cur.to);
            check("r_valid_cycle", cyc, cur.vcyc);
            check("run_cycle", run_cyc, cur.rcyc);
            check("run_pulses", run_cnt, 1);
          end
          run_cnt = 0;
        end else begin
          check("r_class_stable", bus.r_class, h_cls);
          check("r_score_stable", bus.r_score, h_score);
          check("r_timeout_stable", bus.r_timeout, h_to);
        end
        if (bus.r_ready) begin
          seen   = 1'b0;
          hs_cyc = cyc;
        end
      end
    end
  end

  // Reference: argmax over plain integers, first index wins ties; edge
  // D cycles after Run is seen unless it falls past the timeout window.
  task automatic push_expected(input int a, input int b, input int c, input int d,
                               input int acc);
    exp_t e;
    int   v[3];
    int   best;
    v = '{a, b, c};
    e.rcyc = acc + 1;
    if (d >= 1 && d <= TIMEOUT) begin
      best = 0;
      for (int i = 1; i < 3; i++) if (v[i] > v[best]) best = i;
      e.cls   = 2'(best);
      e.score = YW'(v[best]);
      e.to    = 1'b0;
      e.vcyc  = acc + d + 3;
    end else begin
      e.cls   = 2'd3;
      e.score = '0;
      e.to    = 1'b1;
      e.vcyc  = acc + TIMEOUT + 2;
    end
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] data, input int a, input int b, input int c,
                      input int d, input logic pre, input int drop, output int acc);
    @(negedge clk);
    y1 = YW'(a);
    y2 = YW'(b);
    y3 = YW'(c);
    stub_delay = d;
    stub_pre   = pre;
    stub_drop  = drop;
    @(negedge clk);
    @(negedge clk);
    bus.s_data  = data;
    bus.s_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.s_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL accept_wait no s_ready within 300 cycles");
      bus.s_valid = 1'b0;
    end else begin
      push_expected(a, b, c, d, acc);
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      check("nn_x1", x1, data[7:0]);
      check("nn_x2", x2, data[15:8]);
      check("nn_x3", x3, data[23:16]);
      check("nn_x4", x4, data[31:24]);
    end
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.r_valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_wait pending=%0d r_valid=%0d busy=%0d", sb.size(), bus.r_valid,
               busy);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  int acc, acc_b;

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    y1 = '0; y2 = '0; y3 = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_nn_en", nn_en, 0);
    check("rst_nn_run", nn_run, 0);
    check("rst_busy", busy, 0);
    check("rst_nn_x", {x4, x3, x2, x1}, 0);
    check("rst_r_class", bus.r_class, 0);
    check("rst_r_score", bus.r_score, 0);
    check("rst_r_timeout", bus.r_timeout, 0);
    rst = 1'b0;

    // Basic inference, then signed ties and sign-sensitive compares.
    send(32'h050A141E, -3, 40, 12, 12, 1'b0, 0, acc);
    wait_done();
    send(32'h11223344, 25, 25, -1, 5, 1'b0, 0, acc);
    wait_done();
    send(32'hA5A55A5A, -8191, -8192, -8192, 3, 1'b0, 0, acc);
    wait_done();
    send(32'h01020304, -8192, 8191, -1, 2, 1'b0, 0, acc);
    wait_done();
    send(32'hDEADBEEF, 7, 7, 7, 1, 1'b0, 0, acc);
    wait_done();

    // Timeout window: never, last cycle (edge wins), one past.
    send(32'h0F0F0F0F, 1, 2, 3, 0, 1'b0, 0, acc);
    wait_done();
    send(32'hF0F0F0F0, 1, 2, 3, TIMEOUT, 1'b0, 0, acc);
    wait_done();
    send(32'h12345678, 1, 2, 3, TIMEOUT + 1, 1'b0, 0, acc);
    wait_done();

    // Ready[2] already high before START: only the later 0->1 edge counts.
    send(32'h87654321, 100, -100, 200, 5, 1'b1, 2, acc);
    wait_done();
    stub_pre = 1'b0;

    // Held-off result with next sample waiting.
    rr_hold = 10;
    send(32'hCAFEF00D, 3, 2, 1, 3, 1'b0, 0, acc);
    for (int i = 0; i < 100 && !bus.r_valid; i++) @(negedge clk);
    send(32'h0BADC0DE, -5, -6, -4, 4, 1'b0, 0, acc_b);
    check("accept_after_handshake", acc_b, hs_cyc + 1);
    wait_done();

    // Reset in WAIT aborts the inference; next one completes normally.
    send(32'h13579BDF, 9, 8, 7, 0, 1'b0, 0, acc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_nn_en", nn_en, 0);
    check("midrst_nn_run", nn_run, 0);
    check("midrst_busy", busy, 0);
    check("midrst_r_valid", bus.r_valid, 0);
    check("midrst_nn_x1", x1, 0);
    send(32'h2468ACE0, 0, -1, 1, 6, 1'b0, 0, acc);
    wait_done();

    // Randomized inferences including some timeouts.
    for (int n = 0; n < 25; n++) begin
      send($urandom, int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
           int'($urandom_range(16383)) - 8192, int'($urandom_range(TIMEOUT + 4)), 1'b0, 0,
           acc);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
